instruction_decoder: RTL and testbench
======================================

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, the width of the fetch address and PC.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, the width of the instruction word.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, the first fetch address after reset.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock, all state on posedge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 startLoading  output  1  one-cycle fetch request to the opcode buffer.
REQ-007 ip  output  ADDRESS_WIDTH  fetch address to the opcode buffer.
REQ-008 bufBusy  input  1  opcode buffer busy.
REQ-009 bufOpcode  input  WORD_WIDTH  assembled instruction word from the opcode buffer.
REQ-010 redirect  input  1  branch/jump redirect from execute.
REQ-011 redirectIp  input  ADDRESS_WIDTH  redirect target.
REQ-012 decValid  output  1  decoded bundle valid.
REQ-013 decReady  input  1  execute accepts the bundle.
REQ-014 instrIp  output  ADDRESS_WIDTH  address of the decoded instruction.
REQ-015 op/rs/rt/rd/shamt/funct  output  6/5/5/5/5/6  MIPS fields.
REQ-016 imm  output  32  sign-extended imm16.
REQ-017 target  output  26  J-type target.
REQ-018 instrType  output  2  R=0, I=1, J=2.
REQ-019 illegal  output  1  unsupported opcode flag.

Function
REQ-020 SHALL implement the FSM states IDLE, FETCH, WAIT_ACK, WAIT_DATA and HOLD.
REQ-021 IDLE SHALL last one cycle after reset and then go to FETCH.
REQ-022 In FETCH, startLoading SHALL be 1 for exactly one cycle with ip stable, and the FSM SHALL then go to WAIT_ACK.
REQ-023 WAIT_ACK SHALL wait for bufBusy=1 and then go to WAIT_DATA.
REQ-024 In WAIT_DATA, on the first cycle with bufBusy=0 the block SHALL latch bufOpcode, decode it, and go to HOLD.
REQ-025 decValid SHALL be 1 on the cycle after bufBusy falls.
REQ-026 In HOLD, all decoded outputs SHALL stay stable while decValid=1 and decReady=0.
REQ-027 On decValid and decReady both 1, the block SHALL set ip=ip+4 (modulo 2^ADDRESS_WIDTH, wrap silently), drop decValid the next cycle, and go to FETCH.
REQ-028 Decode SHALL be op=w[31:26], rs=w[25:21], rt=w[20:16], rd=w[15:11], shamt=w[10:6], funct=w[5:0], target=w[25:0].
REQ-029 imm SHALL be {16{w[15]}, w[15:0]}.
REQ-030 instrType SHALL be R if op=0, J if op is 2 or 3, and I otherwise.
REQ-031 A redirect in any non-reset state SHALL load ip=redirectIp and take priority over the +4 increment.
REQ-032 A redirect in FETCH or HOLD SHALL clear decValid next cycle and go to FETCH.
REQ-033 A redirect in WAIT_ACK or WAIT_DATA SHALL set a squash flag.
REQ-034 When the squashed word returns it SHALL be discarded with no decValid, the squash flag cleared, and the FSM SHALL go to FETCH.
REQ-035 Redirect coincident with a decValid/decReady handshake SHALL still count the bundle as accepted, with next ip=redirectIp.
REQ-036 redirectIp SHALL be used as-given; there is no alignment check.

Reset
REQ-037 Reset SHALL force state=IDLE, ip=RESET_VECTOR, startLoading=0, decValid=0, squash=0, all decoded fields and instrIp 0, and illegal=0.
REQ-038 Reset SHALL take priority over every other input, including mid-fetch; a late bufBusy fall after reset SHALL be ignored (the FSM is not in WAIT_DATA).

Configuration
REQ-039 Macro DECODER_ILLEGAL_TRAP_EN defined: illegal=1 with decValid when op is not in the package's supported-opcode list, and the field outputs are still driven.
REQ-040 Macro DECODER_ILLEGAL_TRAP_EN undefined: illegal SHALL be tied to 0 and no lookup logic compiled.

Structure
REQ-041 Package decoder_pkg SHALL hold the FSM state enum, the instrType encoding, the MIPS opcode constants, and the supported-opcode list.
REQ-042 The combinational field extraction and sign-extension SHALL live in sub-module instruction_fields.
REQ-043 The FSM, PC, squash flag and output register SHALL live in instruction_decoder.

Verification
REQ-044 Reset release, buffer model returns 0x012A4020 after 4 busy cycles -> startLoading at ip=0; decValid the cycle after busy falls; instrType=R; rs=9, rt=10, rd=8, funct=0x20.
REQ-045 Word 0x2108FFFC with decReady held 0 for 5 cycles -> instrType=I, imm=0xFFFFFFFC, outputs stable 5 cycles, no new startLoading; after the handshake the next fetch uses ip=4.
REQ-046 redirect with redirectIp=0x100 during WAIT_DATA -> returning word dropped (no decValid); next startLoading at ip=0x100.
REQ-047 Word 0x0C000040 accepted in the same cycle as redirect to 0x200 -> bundle consumed once, instrType=J, target=0x40; next ip=0x200.
REQ-048 ip=0xFFFFFFFC handshake -> next ip=0; reset asserted in WAIT_ACK -> ip=RESET_VECTOR, decValid=0.
REQ-049 Op 0x3F with DECODER_ILLEGAL_TRAP_EN defined -> illegal=1 with decValid; same op with the macro undefined -> illegal=0.

Source files
------------

// File: rtl/instruction_decoder_pkg.sv
// Shared definitions for the instruction decoder slice: FSM state codes,
// instruction-type encoding, MIPS opcode constants, the supported-opcode
// list used by the optional illegal-opcode trap (DECODER_ILLEGAL_TRAP_EN),
// and the decoded-field bundle.
package decoder_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_FETCH     = 3'd1;
    localparam state_t ST_WAIT_ACK  = 3'd2;
    localparam state_t ST_WAIT_DATA = 3'd3;
    localparam state_t ST_HOLD      = 3'd4;

    // instrType encoding
    localparam logic [1:0] ITYPE_R = 2'd0;
    localparam logic [1:0] ITYPE_I = 2'd1;
    localparam logic [1:0] ITYPE_J = 2'd2;

    // MIPS opcode constants
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Opcodes the execute stage implements
    localparam int NUM_SUPPORTED_OPS = 23;
    localparam logic [5:0] SUPPORTED_OPS [NUM_SUPPORTED_OPS] = '{
        OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
        OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW
    };

    // Decoded instruction bundle
    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic [25:0] target;
        logic [1:0]  itype;
    } fields_t;

    // Membership test against the supported-opcode list
    function automatic logic is_supported_op(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SUPPORTED_OPS; i++) begin
            if (SUPPORTED_OPS[i] == op) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/instruction_decoder_if.sv
// Fetch/decode bus of the instruction decoder: request/response signals to
// the opcode buffer, redirect from execute, and the decoded bundle with its
// valid/ready handshake. master = decoder side, slave = environment side.
interface instruction_decoder_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int WORD_WIDTH    = 32
);
    logic                     startLoading;
    logic [ADDRESS_WIDTH-1:0] ip;
    logic                     bufBusy;
    logic [WORD_WIDTH-1:0]    bufOpcode;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirectIp;
    logic                     decValid;
    logic                     decReady;
    logic [ADDRESS_WIDTH-1:0] instrIp;
    logic [5:0]               op;
    logic [4:0]               rs;
    logic [4:0]               rt;
    logic [4:0]               rd;
    logic [4:0]               shamt;
    logic [5:0]               funct;
    logic [31:0]              imm;
    logic [25:0]              target;
    logic [1:0]               instrType;
    logic                     illegal;

    modport master (
        output startLoading, ip, decValid, instrIp, op, rs, rt, rd, shamt,
               funct, imm, target, instrType, illegal,
        input  bufBusy, bufOpcode, redirect, redirectIp, decReady
    );

    modport slave (
        input  startLoading, ip, decValid, instrIp, op, rs, rt, rd, shamt,
               funct, imm, target, instrType, illegal,
        output bufBusy, bufOpcode, redirect, redirectIp, decReady
    );
endinterface

// File: rtl/instruction_decoder_fields.sv
// Combinational MIPS field extraction, imm16 sign extension and
// instruction-type classification of one 32-bit instruction word.
module instruction_fields
    import decoder_pkg::*;
(
    input  logic [31:0] word,
    output fields_t     fields
);

    fields_t fields_s;

    // Slice the word into its fields and classify R/I/J by opcode
    always_comb begin
        fields_s        = '0;
        fields_s.op     = word[31:26];
        fields_s.rs     = word[25:21];
        fields_s.rt     = word[20:16];
        fields_s.rd     = word[15:11];
        fields_s.shamt  = word[10:6];
        fields_s.funct  = word[5:0];
        fields_s.target = word[25:0];
        fields_s.imm    = {{16{word[15]}}, word[15:0]};
        if (word[31:26] == OP_RTYPE) begin
            fields_s.itype = ITYPE_R;
        end else if ((word[31:26] == OP_J) || (word[31:26] == OP_JAL)) begin
            fields_s.itype = ITYPE_J;
        end else begin
            fields_s.itype = ITYPE_I;
        end
    end

    assign fields = fields_s;

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: drives single-cycle fetch requests to the opcode
// buffer, waits for the busy pulse to complete, registers the decoded word
// and holds it until execute accepts it. Redirects reload the PC; a redirect
// that lands while a fetch is outstanding squashes the returning word.
// Optional feature macro: DECODER_ILLEGAL_TRAP_EN (flags unsupported opcodes).
module instruction_decoder
    import decoder_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       WORD_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = {ADDRESS_WIDTH{1'b0}}
) (
    input logic                   clk,
    input logic                   reset,
    instruction_decoder_if.master bus
);

    localparam logic [ADDRESS_WIDTH-1:0] IP_STEP = {{(ADDRESS_WIDTH-3){1'b0}}, 3'b100};

    state_t                   state_r;
    state_t                   state_s;
    logic [ADDRESS_WIDTH-1:0] ip_r;
    logic [ADDRESS_WIDTH-1:0] ip_s;
    logic                     start_r;
    logic                     start_s;
    logic                     dec_valid_r;
    logic                     dec_valid_s;
    logic                     squash_r;
    logic                     squash_s;
    logic                     latch_s;
    logic [ADDRESS_WIDTH-1:0] instr_ip_r;
    fields_t                  fields_r;
    fields_t                  dec_fields_s;

    instruction_fields u_fields (
        .word   (bus.bufOpcode[31:0]),
        .fields (dec_fields_s)
    );

    // Next-state, PC, squash and valid computation
    always_comb begin
        state_s     = state_r;
        ip_s        = ip_r;
        dec_valid_s = dec_valid_r;
        squash_s    = squash_r;
        latch_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
                if (bus.redirect) begin
                    ip_s = bus.redirectIp;
                end else begin
                    ip_s = ip_r;
                end
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    ip_s        = bus.redirectIp;
                    dec_valid_s = 1'b0;
                    state_s     = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (bus.redirect) begin
                    ip_s     = bus.redirectIp;
                    squash_s = 1'b1;
                end else begin
                    squash_s = squash_r;
                end
                if (bus.bufBusy) begin
                    state_s = ST_WAIT_DATA;
                end else begin
                    state_s = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DATA: begin
                if (bus.redirect) begin
                    ip_s = bus.redirectIp;
                end else begin
                    ip_s = ip_r;
                end
                if (bus.bufBusy) begin
                    // still loading; a redirect now marks the word stale
                    squash_s = squash_r | bus.redirect;
                end else if (squash_r || bus.redirect) begin
                    // stale word: drop it and refetch from the new PC
                    squash_s = 1'b0;
                    state_s  = ST_FETCH;
                end else begin
                    latch_s     = 1'b1;
                    dec_valid_s = 1'b1;
                    state_s     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // a redirect wins over +4 even when the bundle is accepted
                if (bus.redirect) begin
                    ip_s        = bus.redirectIp;
                    dec_valid_s = 1'b0;
                    state_s     = ST_FETCH;
                end else if (bus.decReady) begin
                    ip_s        = ip_r + IP_STEP;
                    dec_valid_s = 1'b0;
                    state_s     = ST_FETCH;
                end else begin
                    state_s = ST_HOLD;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                dec_valid_s = 1'b0;
                squash_s    = 1'b0;
            end
        endcase
        start_s = (state_s == ST_FETCH);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ip_r        <= RESET_VECTOR;
            start_r     <= 1'b0;
            dec_valid_r <= 1'b0;
            squash_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            ip_r        <= ip_s;
            start_r     <= start_s;
            dec_valid_r <= dec_valid_s;
            squash_r    <= squash_s;
        end
    end

    // Decoded-bundle output register, loaded only when a word is accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            fields_r   <= '0;
            instr_ip_r <= {ADDRESS_WIDTH{1'b0}};
        end else if (latch_s) begin
            fields_r   <= dec_fields_s;
            instr_ip_r <= ip_r;
        end else begin
            fields_r   <= fields_r;
            instr_ip_r <= instr_ip_r;
        end
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Illegal-opcode flag registered alongside the decoded fields
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else if (latch_s) begin
            illegal_r <= ~is_supported_op(dec_fields_s.op);
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign bus.illegal = illegal_r;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.startLoading = start_r;
    assign bus.ip           = ip_r;
    assign bus.decValid     = dec_valid_r;
    assign bus.instrIp      = instr_ip_r;
    assign bus.op           = fields_r.op;
    assign bus.rs           = fields_r.rs;
    assign bus.rt           = fields_r.rt;
    assign bus.rd           = fields_r.rd;
    assign bus.shamt        = fields_r.shamt;
    assign bus.funct        = fields_r.funct;
    assign bus.imm          = fields_r.imm;
    assign bus.target       = fields_r.target;
    assign bus.instrType    = fields_r.itype;

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed scenarios followed by
// randomized transactions, checked against a PC/decode reference model.
module tb_instruction_decoder;

    localparam int AW = 32;
    localparam int WW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_decoder_if #(.ADDRESS_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

    instruction_decoder #(
        .ADDRESS_WIDTH (AW),
        .WORD_WIDTH    (WW),
        .RESET_VECTOR  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_ip;

`ifdef DECODER_ILLEGAL_TRAP_EN
    int legal_ops [23] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                           32, 33, 35, 36, 37, 40, 41, 43};
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected decode computed from the word with plain arithmetic
    task automatic check_bundle(input string tag, input logic [31:0] w, input logic [31:0] iip);
        int unsigned u, op, lo, imm, ty;
        int unsigned ill;
        u   = w;
        op  = u / 67108864;
        lo  = u % 65536;
        imm = (lo >= 32768) ? (lo + 32'hFFFF0000) : lo;
        ty  = (op == 0) ? 0 : ((op == 2 || op == 3) ? 2 : 1);
        ill = 0;
`ifdef DECODER_ILLEGAL_TRAP_EN
        ill = 1;
        foreach (legal_ops[i]) if (legal_ops[i] == int'(op)) ill = 0;
`endif
        check({tag, "_valid"},  64'(bus.decValid),  64'(1));
        check({tag, "_op"},     64'(bus.op),        64'(op));
        check({tag, "_rs"},     64'(bus.rs),        64'((u / 2097152) % 32));
        check({tag, "_rt"},     64'(bus.rt),        64'((u / 65536) % 32));
        check({tag, "_rd"},     64'(bus.rd),        64'((u / 2048) % 32));
        check({tag, "_shamt"},  64'(bus.shamt),     64'((u / 64) % 32));
        check({tag, "_funct"},  64'(bus.funct),     64'(u % 64));
        check({tag, "_imm"},    64'(bus.imm),       64'(imm));
        check({tag, "_target"}, 64'(bus.target),    64'(u % 67108864));
        check({tag, "_type"},   64'(bus.instrType), 64'(ty));
        check({tag, "_illegal"},64'(bus.illegal),   64'(ill));
        check({tag, "_iip"},    64'(bus.instrIp),   64'(iip));
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (bus.startLoading === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) check("start_timeout", 64'(0), 64'(1));
    endtask

    // kind: 0 plain, 1 redirect in FETCH, 2 redirect while loading (squash),
    //       3 redirect in HOLD without accept, 4 redirect with accept
    task automatic run_txn(input logic [31:0] word, input int kind, input logic [31:0] rip,
                           input int busy_n, input int hold_n);
        bit ok;
        logic [31:0] iip;
        wait_start(ok);
        if (!ok) return;
        check("fetch_ip", 64'(bus.ip), 64'(model_ip));
        if (kind == 1) begin
            bus.redirect = 1'b1; bus.redirectIp = rip;
            tick();
            bus.redirect = 1'b0;
            model_ip = rip;
            check("redir_fetch_start", 64'(bus.startLoading), 64'(1));
            check("redir_fetch_ip", 64'(bus.ip), 64'(model_ip));
        end
        bus.bufBusy = 1'b1; bus.bufOpcode = $urandom;
        tick();
        check("start_one_cycle", 64'(bus.startLoading), 64'(0));
        for (int i = 1; i < busy_n; i++) begin
            if (kind == 2 && i == 2) begin
                bus.redirect = 1'b1; bus.redirectIp = rip;
            end else begin
                bus.redirect = 1'b0;
            end
            tick();
            check("busy_no_valid", 64'(bus.decValid), 64'(0));
        end
        bus.redirect = 1'b0;
        bus.bufBusy = 1'b0; bus.bufOpcode = word;
        tick();
        bus.bufOpcode = $urandom;
        if (kind == 2) begin
            model_ip = rip;
            check("squash_no_valid", 64'(bus.decValid), 64'(0));
            check("squash_refetch", 64'(bus.startLoading), 64'(1));
            check("squash_ip", 64'(bus.ip), 64'(model_ip));
            return;
        end
        iip = model_ip;
        check_bundle("dec", word, iip);
        for (int i = 0; i < hold_n; i++) begin
            tick();
            check_bundle("hold", word, iip);
            check("hold_no_start", 64'(bus.startLoading), 64'(0));
        end
        if (kind == 3) begin
            bus.redirect = 1'b1; bus.redirectIp = rip;
            tick();
            bus.redirect = 1'b0;
            model_ip = rip;
            check("hold_redir_valid", 64'(bus.decValid), 64'(0));
            check("hold_redir_start", 64'(bus.startLoading), 64'(1));
            check("hold_redir_ip", 64'(bus.ip), 64'(model_ip));
            return;
        end
        bus.decReady = 1'b1;
        if (kind == 4) begin
            bus.redirect = 1'b1; bus.redirectIp = rip;
        end
        tick();
        bus.decReady = 1'b0; bus.redirect = 1'b0;
        model_ip = (kind == 4) ? rip : model_ip + 32'd4;
        check("accept_valid_drop", 64'(bus.decValid), 64'(0));
        check("accept_refetch", 64'(bus.startLoading), 64'(1));
        check("accept_next_ip", 64'(bus.ip), 64'(model_ip));
    endtask

    initial begin
        bit ok;
        int kind, bn;
        logic [31:0] w;
        reset = 1'b1;
        bus.bufBusy = 1'b0; bus.bufOpcode = '0; bus.redirect = 1'b0;
        bus.redirectIp = '0; bus.decReady = 1'b0;
        model_ip = 32'h0;
        tick(); tick();
        check("rst_start", 64'(bus.startLoading), 64'(0));
        check("rst_valid", 64'(bus.decValid), 64'(0));
        check("rst_ip", 64'(bus.ip), 64'(0));
        check("rst_op", 64'(bus.op), 64'(0));
        check("rst_imm", 64'(bus.imm), 64'(0));
        check("rst_target", 64'(bus.target), 64'(0));
        check("rst_iip", 64'(bus.instrIp), 64'(0));
        check("rst_illegal", 64'(bus.illegal), 64'(0));
        reset = 1'b0;

        run_txn(32'h012A4020, 0, 32'h0, 4, 0);
        run_txn(32'h2108FFFC, 0, 32'h0, 3, 5);
        run_txn(32'h8C421234, 2, 32'h100, 4, 0);
        run_txn(32'h0C000040, 4, 32'h200, 3, 1);
        run_txn(32'h3C01ABCD, 1, 32'hFFFFFFFC, 2, 0);
        run_txn(32'hFC0012AB, 0, 32'h0, 2, 2);
        run_txn(32'h00851822, 3, 32'h33, 2, 1);

        // reset while the fetch is waiting for the buffer acknowledge
        wait_start(ok);
        check("pre_rst_ip", 64'(bus.ip), 64'(model_ip));
        tick();
        reset = 1'b1; bus.bufBusy = 1'b1;
        tick();
        check("midrst_ip", 64'(bus.ip), 64'(0));
        check("midrst_valid", 64'(bus.decValid), 64'(0));
        check("midrst_start", 64'(bus.startLoading), 64'(0));
        reset = 1'b0; bus.bufBusy = 1'b0;
        model_ip = 32'h0;
        tick();
        check("late_fall_no_valid", 64'(bus.decValid), 64'(0));
        run_txn(32'h2402FFFF, 0, 32'h0, 3, 0);

        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 4);
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:26] = 6'h3F;
            bn = (kind == 2) ? $urandom_range(3, 6) : $urandom_range(2, 6);
            run_txn(w, kind, $urandom, bn, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
